// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch / next-PC stage in front of the single-cycle execute
//   datapath. Owns the PC, fetches 16-bit words over a ready-based memory
//   handshake, holds each word for execute, and resolves B / BR / HLT against
//   the flags returned on retire.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_addr, imem_req fetch address (== pc) and request
//   imem_rdy, imem_data memory data valid strobe and instruction word
//   instr, instr_valid  registered instruction presented to decode
//   instr_ack           execute retires instr this cycle
//   flags               {Z,V,N} from execute, used only on ack
//   br_reg_data         rs value for BR, used only on ack
//   pc, pc_plus2        current PC and PC+2 (PCS write data)
//   hlt                 high once HLT has retired
//   retired             saturating retired-instruction count
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [15:0]      imem_addr,
  output logic             imem_req,
  input  logic             imem_rdy,
  input  logic [15:0]      imem_data,
  output logic [15:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ack,
  input  logic [2:0]       flags,
  input  logic [15:0]      br_reg_data,
  output logic [15:0]      pc,
  output logic [15:0]      pc_plus2,
  output logic             hlt,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0]       opcode;
  logic [2:0]       ccc;
  logic             flag_z, flag_v, flag_n;
  logic             cond_taken;
  logic             retire;
  logic [15:0]      pc_seq;
  logic [15:0]      br_offset;
  logic [15:0]      b_target;

  assign opcode = instr_q[15:12];
  assign ccc    = instr_q[11:9];
  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (imem_rdy) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ack) begin
          state_d = (opcode == OP_HLT) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // The request is masked during reset so a reset cycle never issues a fetch,
  // even though the state register may still show FETCH.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    hlt         = 1'b0;
    case (state_q)
      FETCH:   imem_req    = ~rst;
      ISSUE:   instr_valid = 1'b1;
      HALTED:  hlt         = 1'b1;
      default: imem_req    = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus2  = pc_seq;
  assign instr     = instr_q;
  assign retired   = retired_q;

  // ---------------------------------------------------------------------------
  // Branch condition evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    cond_taken = 1'b0;
    case (ccc)
      3'b000: cond_taken = ~flag_z;
      3'b001: cond_taken = flag_z;
      3'b010: cond_taken = ~flag_z & ~flag_n;
      3'b011: cond_taken = flag_n;
      3'b100: cond_taken = flag_z | (~flag_z & ~flag_n);
      3'b101: cond_taken = flag_n | flag_z;
      3'b110: cond_taken = flag_v;
      3'b111: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC / instruction / counter datapath
  // ---------------------------------------------------------------------------
  // 9-bit offset is sign-extended, then scaled to bytes; all sums wrap mod 2^16.
  assign pc_seq    = pc_q + 16'd2;
  assign br_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
  assign b_target  = pc_seq + br_offset;
  assign retire    = (state_q == ISSUE) && instr_ack;

  always_comb begin
    instr_d = instr_q;
    if ((state_q == FETCH) && imem_rdy) begin
      instr_d = imem_data;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (retire) begin
      case (opcode)
        OP_B:    pc_d = cond_taken ? b_target : pc_seq;
        OP_BR:   pc_d = cond_taken ? br_reg_data : pc_seq;
        OP_HLT:  pc_d = pc_q;
        default: pc_d = pc_seq;
      endcase
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != '1)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [2:0]  flags;
  logic [15:0] br_reg_data;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        hlt;
  logic [15:0] retired;

  // Narrow-counter instance sharing the same stimulus, to reach saturation.
  logic [15:0] s_imem_addr;
  logic        s_imem_req;
  logic [15:0] s_instr;
  logic        s_instr_valid;
  logic [15:0] s_pc;
  logic [15:0] s_pc_plus2;
  logic        s_hlt;
  logic [1:0]  s_retired;

  fetch_unit #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .flags(flags),
    .br_reg_data(br_reg_data), .pc(pc), .pc_plus2(pc_plus2), .hlt(hlt),
    .retired(retired)
  );

  fetch_unit #(.RESET_PC(16'h0000), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .imem_addr(s_imem_addr), .imem_req(s_imem_req),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instr(s_instr),
    .instr_valid(s_instr_valid), .instr_ack(instr_ack), .flags(flags),
    .br_reg_data(br_reg_data), .pc(s_pc), .pc_plus2(s_pc_plus2), .hlt(s_hlt),
    .retired(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] data;
    logic        ack;
    logic [2:0]  flags;
    logic [15:0] brd;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic        hlt;
    int          ret;
  } vec_t;

  localparam logic [15:0] ADD  = 16'h1000;
  localparam logic [15:0] BRA  = 16'hDE00; // BR always
  localparam logic [15:0] BNE  = 16'hD000; // BR if Z=0
  localparam logic [15:0] BEQ  = 16'hC3FE; // B EQ, offset -2
  localparam logic [15:0] HLTI = 16'hF000;

  vec_t vq[$];
  int   n_checks;
  int   n_fail;
  int   step;

  function automatic vec_t V(logic r, logic rdy, logic [15:0] d, logic a,
                             logic [2:0] f, logic [15:0] b, logic q,
                             logic [15:0] ad, logic vl, logic [15:0] ins,
                             logic h, int rt);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.data = d; v.ack = a; v.flags = f; v.brd = b;
    v.req = q; v.addr = ad; v.valid = vl; v.instr = ins; v.hlt = h; v.ret = rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
    end
  endtask

  function automatic logic taken(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Reset for one edge then release with idle inputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_rdy = 1'b0; instr_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    step     = 0;
    rst = 1'b1; imem_rdy = 1'b0; imem_data = '0; instr_ack = 1'b0;
    flags = '0; br_reg_data = '0;

    //            rst rdy data     ack flg     brd       req addr      vld instr    hlt ret
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 0));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0000, 1, ADD,      0, 0));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 1, 16'h0002, 0, ADD,      0, 1));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0002, 1, ADD,      0, 1));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 1, 16'h0004, 0, ADD,      0, 2));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0004, 1, ADD,      0, 2));
    vq.push_back(V(0, 0, ADD,     1, 3'b000, 16'h0000, 1, 16'h0006, 0, ADD,      0, 3));
    vq.push_back(V(0, 0, ADD,     1, 3'b000, 16'h0000, 1, 16'h0006, 0, ADD,      0, 3));
    vq.push_back(V(0, 0, ADD,     1, 3'b000, 16'h0000, 1, 16'h0006, 0, ADD,      0, 3));
    vq.push_back(V(1, 1, 16'h5555,1, 3'b000, 16'h0000, 0, 16'h0006, 0, ADD,      0, 3));
    vq.push_back(V(0, 0, ADD,     1, 3'b000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 0));
    vq.push_back(V(0, 0, ADD,     1, 3'b000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 0));
    vq.push_back(V(0, 1, 16'h2345,0, 3'b000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 0));
    vq.push_back(V(0, 0, 16'h0000,0, 3'b000, 16'h0000, 0, 16'h0000, 1, 16'h2345, 0, 0));
    vq.push_back(V(0, 1, 16'h0000,1, 3'b000, 16'h0000, 0, 16'h0000, 1, 16'h2345, 0, 0));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 1, 16'h0002, 0, 16'h2345, 0, 1));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 1, 16'h0002, 0, 16'h2345, 0, 1));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 1, 16'h0002, 0, 16'h2345, 0, 1));
    vq.push_back(V(0, 1, BRA,     0, 3'b000, 16'h0000, 1, 16'h0002, 0, 16'h2345, 0, 1));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0010, 0, 16'h0002, 1, BRA,      0, 1));
    vq.push_back(V(0, 1, BEQ,     0, 3'b000, 16'h0000, 1, 16'h0010, 0, BRA,      0, 2));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b100, 16'h0000, 0, 16'h0010, 1, BEQ,      0, 2));
    vq.push_back(V(0, 1, BEQ,     0, 3'b000, 16'h0000, 1, 16'h000E, 0, BEQ,      0, 3));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 0, 16'h000E, 1, BEQ,      0, 3));
    vq.push_back(V(0, 1, BEQ,     0, 3'b000, 16'h0000, 1, 16'h0010, 0, BEQ,      0, 4));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 0, 16'h0010, 1, BEQ,      0, 4));
    vq.push_back(V(0, 1, BRA,     0, 3'b000, 16'h0000, 1, 16'h0012, 0, BEQ,      0, 5));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h1234, 0, 16'h0012, 1, BRA,      0, 5));
    vq.push_back(V(0, 1, BRA,     0, 3'b000, 16'h0000, 1, 16'h1234, 0, BRA,      0, 6));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'hFFFE, 0, 16'h1234, 1, BRA,      0, 6));
    vq.push_back(V(0, 1, ADD,     0, 3'b000, 16'h0000, 1, 16'hFFFE, 0, BRA,      0, 7));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 0, 16'hFFFE, 1, ADD,      0, 7));
    vq.push_back(V(0, 1, BNE,     0, 3'b000, 16'h0000, 1, 16'h0000, 0, ADD,      0, 8));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b100, 16'hABCD, 0, 16'h0000, 1, BNE,      0, 8));
    vq.push_back(V(0, 1, BRA,     0, 3'b000, 16'h0000, 1, 16'h0002, 0, BNE,      0, 9));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0008, 0, 16'h0002, 1, BRA,      0, 9));
    vq.push_back(V(0, 1, HLTI,    0, 3'b000, 16'h0000, 1, 16'h0008, 0, BRA,      0, 10));
    vq.push_back(V(0, 0, 16'h0000,1, 3'b000, 16'h0000, 0, 16'h0008, 1, HLTI,     0, 10));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0008, 0, HLTI,     1, 11));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0008, 0, HLTI,     1, 11));
    vq.push_back(V(0, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0008, 0, HLTI,     1, 11));
    vq.push_back(V(1, 1, ADD,     1, 3'b000, 16'h0000, 0, 16'h0008, 0, HLTI,     1, 11));
    vq.push_back(V(0, 1, ADD,     0, 3'b000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 0));
    vq.push_back(V(0, 0, 16'h0000,0, 3'b000, 16'h0000, 0, 16'h0000, 1, ADD,      0, 0));

    // First posedge (t=5) sees rst=1; the table starts at the following negedge.
    foreach (vq[i]) begin
      @(negedge clk);
      step        = i;
      rst         = vq[i].rst;
      imem_rdy    = vq[i].rdy;
      imem_data   = vq[i].data;
      instr_ack   = vq[i].ack;
      flags       = vq[i].flags;
      br_reg_data = vq[i].brd;
      #1;
      chk("imem_req",    32'(imem_req),    32'(vq[i].req));
      chk("imem_addr",   32'(imem_addr),   32'(vq[i].addr));
      chk("pc",          32'(pc),          32'(vq[i].addr));
      chk("pc_plus2",    32'(pc_plus2),    32'(16'(vq[i].addr + 16'd2)));
      chk("instr_valid", 32'(instr_valid), 32'(vq[i].valid));
      chk("instr",       32'(instr),       32'(vq[i].instr));
      chk("hlt",         32'(hlt),         32'(vq[i].hlt));
      chk("retired",     32'(retired),     32'(vq[i].ret));
      chk("retired_sat", 32'(s_retired),   32'((vq[i].ret > 3) ? 3 : vq[i].ret));
    end

    // Every condition code against every flag combination: B with offset +4
    // from pc 0 lands at 000A when taken, 0002 otherwise.
    step = 1000;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [15:0] w;
        logic [15:0] exp_pc;
        w = {4'hC, 3'(c), 9'd4};
        exp_pc = taken(3'(c), 3'(f)) ? 16'h000A : 16'h0002;
        do_reset();
        imem_rdy = 1'b1; imem_data = w;
        @(negedge clk);
        imem_rdy = 1'b0; instr_ack = 1'b1; flags = 3'(f);
        @(negedge clk);
        instr_ack = 1'b0;
        #1;
        step = 1000 + c * 8 + f;
        chk("b_cond_target", 32'(imem_addr), 32'(exp_pc));
      end
    end

    // Taken backward branch from pc 0 wraps below zero: 0+2-4 = FFFE.
    step = 2000;
    do_reset();
    imem_rdy = 1'b1; imem_data = 16'hCFFE;
    @(negedge clk);
    imem_rdy = 1'b0; instr_ack = 1'b1; flags = 3'b000;
    @(negedge clk);
    instr_ack = 1'b0;
    #1;
    chk("b_wrap_target", 32'(imem_addr), 32'h0000_FFFE);
    chk("b_wrap_retired", 32'(retired), 32'd1);

    // Wait states then a single rdy cycle: address must hold, and
    // instr_valid must appear on the very next cycle (bounded wait).
    step = 3000;
    do_reset();
    imem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_addr_hold", 32'(imem_addr), 32'h0);
      chk("wait_no_valid", 32'(instr_valid), 32'h0);
      @(negedge clk);
    end
    imem_rdy = 1'b1; imem_data = 16'h7A5C;
    @(negedge clk);
    imem_rdy = 1'b0;
    begin
      int n;
      n = 0;
      #1;
      while (!instr_valid && n < 4) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rdy_to_valid_latency", 32'(n), 32'd0);
      chk("latched_word", 32'(instr), 32'h7A5C);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
